// File: rtl/lsu_pkg.sv
// Shared types, constants and helper functions for the banked load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BK_DATA = 2'd0,
    BK_OUT  = 2'd1,
    BK_IN   = 2'd2,
    BK_NONE = 2'd3
  } bank_class_e;

  // Output-register indices within the output-peripheral bank
  localparam int OREG_LCD  = 0;
  localparam int OREG_LEDG = 1;
  localparam int OREG_LEDR = 2;
  localparam int OREG_HEX0 = 3;
  localparam int OREG_HEX7 = 10;

  // Classify a bank-select value: data RAM, output regs, input regs, or nothing
  function automatic bank_class_e bank_class(input int bsel, input int num_dbanks);
    if (bsel < num_dbanks) begin
      return BK_DATA;
    end else if (bsel == num_dbanks) begin
      return BK_OUT;
    end else if (bsel == num_dbanks + 1) begin
      return BK_IN;
    end else begin
      return BK_NONE;
    end
  endfunction

  // Reserved funct3 encodings for loads and stores
  function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return (funct3 > 3'b010);
    end else begin
      case (funct3)
        3'b011, 3'b110, 3'b111: return 1'b1;
        default:                return 1'b0;
      endcase
    end
  endfunction

  // Halfwords need an even address, words a multiple of four
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Byte lanes touched by a store of the given size at the given offset
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Merge sub-word store data into an existing word
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [2:0] funct3, input logic [1:0] off);
    logic [31:0] rep;
    logic [3:0]  be;
    logic [31:0] mask;
    case (funct3[1:0])
      2'b00:   rep = {4{wdata[7:0]}};
      2'b01:   rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    be   = store_be(funct3, off);
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (rep & mask);
  endfunction

  // Pick the addressed byte/halfword and sign- or zero-extend it
  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (funct3)
      F3_LB:   return {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   return {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  return {24'h000000, shifted[7:0]};
      F3_LHU:  return {16'h0000, shifted[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_banked_sram_bank.sv
// Single-port synchronous-read word RAM; contents are deliberately not reset.
module lsu_sram_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int BANK_AW    = 6
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [BANK_AW-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**BANK_AW];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read data only refreshes on an enabled read, so it stays put across a write
  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !we_i) begin
      rdata_d = mem_q[addr_i];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage array and read register
  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_banked.sv
// Banked load/store unit: data RAM banks plus output and input peripheral banks.
module lsu_banked
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_AW    = 6,
  parameter int NUM_DBANKS = 4,
  parameter int BSEL_W     = 3,
  parameter int NUM_OREGS  = 11,
  parameter int NUM_IREGS  = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_we_i,
  input  logic [ADDR_WIDTH-1:0]           req_addr_i,
  input  logic [2:0]                      req_funct3_i,
  input  logic [DATA_WIDTH-1:0]           req_wdata_i,
  output logic                            rsp_valid_o,
  output logic                            rsp_err_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  input  logic [NUM_IREGS*DATA_WIDTH-1:0] io_in_i,
  output logic [NUM_OREGS*DATA_WIDTH-1:0] io_out_o
);

  localparam int BSEL_LO = BANK_AW + 2;
  localparam int BSEL_HI = BANK_AW + BSEL_W + 1;

  // Request decode
  logic [BANK_AW-1:0]    widx_s;
  logic [BSEL_W-1:0]     bsel_s;
  logic [1:0]            off_s;
  bank_class_e           class_s;
  logic                  unmapped_s;
  logic                  fault_s;
  logic [DATA_WIDTH-1:0] out_word_s;
  logic [DATA_WIDTH-1:0] in_word_s;
  logic                  unused_addr_s;

  // RAM port
  logic [NUM_DBANKS-1:0] bank_en_s;
  logic [DATA_WIDTH-1:0] bank_rdata_s [NUM_DBANKS];
  logic [DATA_WIDTH-1:0] bank_rsel_s;
  logic                  ram_en_s;
  logic                  ram_we_s;
  logic [BSEL_W-1:0]     ram_bsel_s;
  logic [BANK_AW-1:0]    ram_addr_s;
  logic [DATA_WIDTH-1:0] ram_wdata_s;

  // Registered state
  state_e                state_d, state_q;
  logic                  we_d, we_q, err_d, err_q, src_ram_d, src_ram_q;
  logic [2:0]            f3_d, f3_q;
  logic [1:0]            off_d, off_q;
  logic [BANK_AW-1:0]    widx_d, widx_q;
  logic [BSEL_W-1:0]     bsel_d, bsel_q;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q, wdata_d, wdata_q;
  logic [DATA_WIDTH-1:0] oreg_d [NUM_OREGS];
  logic [DATA_WIDTH-1:0] oreg_q [NUM_OREGS];
  logic [NUM_IREGS*DATA_WIDTH-1:0] sync1_q, sync2_q;

  assign widx_s        = req_addr_i[BANK_AW+1:2];
  assign bsel_s        = req_addr_i[BSEL_HI:BSEL_LO];
  assign off_s         = req_addr_i[1:0];
  assign unused_addr_s = ^req_addr_i[ADDR_WIDTH-1:BSEL_HI+1];

  // Classify the incoming request and detect every fault condition
  always_comb begin
    class_s = bank_class(int'(bsel_s), NUM_DBANKS);
    case (class_s)
      BK_DATA: unmapped_s = 1'b0;
      BK_OUT:  unmapped_s = (int'(widx_s) >= NUM_OREGS);
      BK_IN:   unmapped_s = req_we_i || (int'(widx_s) >= NUM_IREGS);
      default: unmapped_s = 1'b1;
    endcase
    fault_s = unmapped_s || f3_illegal(req_we_i, req_funct3_i) || misaligned(req_funct3_i, off_s);
  end

  // Peripheral word addressed by the request, and RAM word of the latched bank
  always_comb begin
    out_word_s  = {DATA_WIDTH{1'b0}};
    in_word_s   = {DATA_WIDTH{1'b0}};
    bank_rsel_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_OREGS; i++) begin
      out_word_s = (widx_s == BANK_AW'(i)) ? oreg_q[i] : out_word_s;
    end
    for (int i = 0; i < NUM_IREGS; i++) begin
      in_word_s = (widx_s == BANK_AW'(i)) ? sync2_q[i*DATA_WIDTH +: DATA_WIDTH] : in_word_s;
    end
    for (int i = 0; i < NUM_DBANKS; i++) begin
      bank_rsel_s = (bsel_q == BSEL_W'(i)) ? bank_rdata_s[i] : bank_rsel_s;
    end
  end

  // Next-state logic: request capture, RAM control and output-register writes
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    err_d       = err_q;
    src_ram_d   = src_ram_q;
    f3_d        = f3_q;
    off_d       = off_q;
    widx_d      = widx_q;
    bsel_d      = bsel_q;
    rdata_d     = rdata_q;
    wdata_d     = wdata_q;
    oreg_d      = oreg_q;
    ram_en_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_bsel_s  = bsel_s;
    ram_addr_s  = widx_s;
    ram_wdata_s = req_wdata_i;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d      = req_we_i;
          err_d     = fault_s;
          src_ram_d = !fault_s && (class_s == BK_DATA);
          f3_d      = req_funct3_i;
          off_d     = off_s;
          widx_d    = widx_s;
          bsel_d    = bsel_s;
          wdata_d   = req_wdata_i;
          rdata_d   = {DATA_WIDTH{1'b0}};
          state_d   = ST_RESP;
          if (fault_s) begin
            state_d = ST_RESP;
          end else if (class_s == BK_DATA) begin
            // Loads and sub-word stores read now; only SW writes straight through
            ram_en_s = 1'b1;
            ram_we_s = req_we_i && (req_funct3_i == F3_SW);
            state_d  = (req_we_i && (req_funct3_i != F3_SW)) ? ST_MERGE : ST_RESP;
          end else if (req_we_i) begin
            // Output registers take sub-word stores as a masked write
            for (int i = 0; i < NUM_OREGS; i++) begin
              oreg_d[i] = (widx_s == BANK_AW'(i))
                          ? store_merge(oreg_q[i], req_wdata_i, req_funct3_i, off_s) : oreg_q[i];
            end
          end else begin
            rdata_d = (class_s == BK_OUT) ? out_word_s : in_word_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MERGE: begin
        ram_en_s    = 1'b1;
        ram_we_s    = 1'b1;
        ram_bsel_s  = bsel_q;
        ram_addr_s  = widx_q;
        ram_wdata_s = store_merge(bank_rsel_s, wdata_q, f3_q, off_q);
        state_d     = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Enable only the bank being accessed
  always_comb begin
    bank_en_s = {NUM_DBANKS{1'b0}};
    for (int i = 0; i < NUM_DBANKS; i++) begin
      bank_en_s[i] = ram_en_s && (ram_bsel_s == BSEL_W'(i));
    end
  end

  // State and request registers; async reset drops any operation in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      src_ram_q <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      widx_q    <= {BANK_AW{1'b0}};
      bsel_q    <= {BSEL_W{1'b0}};
      rdata_q   <= {DATA_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_OREGS; i++) oreg_q[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      err_q     <= err_d;
      src_ram_q <= src_ram_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      widx_q    <= widx_d;
      bsel_q    <= bsel_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      oreg_q    <= oreg_d;
    end
  end

  // Two-flop synchroniser for the raw input peripherals
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= {(NUM_IREGS*DATA_WIDTH){1'b0}};
      sync2_q <= {(NUM_IREGS*DATA_WIDTH){1'b0}};
    end else begin
      sync1_q <= io_in_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NUM_DBANKS; g++) begin : g_bank
    lsu_sram_bank #(.DATA_WIDTH(DATA_WIDTH), .BANK_AW(BANK_AW)) u_bank (
      .clk_i   (clk_i),
      .en_i    (bank_en_s[g]),
      .we_i    (ram_we_s),
      .addr_i  (ram_addr_s),
      .wdata_i (ram_wdata_s),
      .rdata_o (bank_rdata_s[g])
    );
  end

  for (genvar g = 0; g < NUM_OREGS; g++) begin : g_oreg
    assign io_out_o[g*DATA_WIDTH +: DATA_WIDTH] = oreg_q[g];
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = (state_q == ST_RESP) && err_q;

  // Response data: extended load value, zero for stores and faults
  always_comb begin
    rsp_rdata_o = {DATA_WIDTH{1'b0}};
    if ((state_q == ST_RESP) && !we_q && !err_q) begin
      rsp_rdata_o = load_extend(f3_q, off_q, src_ram_q ? bank_rsel_s : rdata_q);
    end else begin
      rsp_rdata_o = {DATA_WIDTH{1'b0}};
    end
  end

endmodule
